// File: rtl/alu_pkg.sv
// alu_pkg: op-codes and error-bit indices shared by the ALU FIFO slice
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_ACC = 3'd5,
        OP_CLR = 3'd6,
        OP_RSV = 3'd7
    } aluOp_e;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_RSV = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: result FIFO with registered read port that holds the last popped entry
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             iClk,
    input  logic             iRsn,
    input  logic             iWrEn,
    input  logic [WIDTH-1:0] iWrData,
    input  logic             iRdEn,
    output logic [WIDTH-1:0] oRdData,
    output logic             oRdValid,
    output logic             oEmpty,
    output logic             oFull,
    output logic             oOverflow,
    output logic             oUnderflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count;
    logic             doRd, doWr;

    // a pop needs data already stored; a write into a full FIFO only fits when a pop frees a slot
    always_comb begin
        doRd       = iRdEn && (count != '0);
        doWr       = iWrEn && ((count != FULL_CNT) || doRd);
        oEmpty     = (count == '0);
        oFull      = (count == FULL_CNT);
        oOverflow  = iWrEn && !doWr;
        oUnderflow = iRdEn && !doRd;
    end

    // storage array carries no reset
    always_ff @(posedge iClk) begin
        if (doWr) mem[wrPtr] <= iWrData;
    end

    // pointers, occupancy and the registered read port
    always_ff @(posedge iClk or posedge iRsn) begin
        if (iRsn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            oRdData  <= '0;
            oRdValid <= 1'b0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) begin
                rdPtr   <= rdPtr + 1'b1;
                oRdData <= mem[rdPtr];
            end
            count    <= count + {{AW{1'b0}}, doWr} - {{AW{1'b0}}, doRd};
            oRdValid <= doRd;
        end
    end

endmodule

// File: rtl/multi_ch_alu_fifo.sv
// multi_ch_alu_fifo: per-channel ALU/accumulator with one stage register feeding a result FIFO
module multi_ch_alu_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iInEnable,
    input  logic [CH_W-1:0]   iInCh,
    input  logic [2:0]        iOpMode,
    input  logic [DATA_W-1:0] iInA,
    input  logic [DATA_W-1:0] iInB,
    input  logic              iOutEnable,
    output logic [DATA_W-1:0] oOutC,
    output logic [CH_W-1:0]   oOutCh,
    output logic              oOutCarry,
    output logic              oOutValid,
    output logic              oEmpty,
    output logic              oFull,
    output logic [2:0]        oErr
);

    localparam int EW = CH_W + 1 + DATA_W;

    logic [DATA_W-1:0] acc [NUM_CH];
    logic [DATA_W-1:0] res, accNew;
    logic [DATA_W:0]   sum, diff, accSum;
    logic              cy, isRsv, stgValid, fifoOvf, fifoUnf;
    logic [EW-1:0]     stgData, rdData;

    // ALU result and next accumulator value for the addressed channel
    always_comb begin
        sum    = {1'b0, iInA} + {1'b0, iInB};
        diff   = {1'b0, iInA} - {1'b0, iInB};
        accSum = {1'b0, acc[iInCh]} + {1'b0, iInA};
        isRsv  = (iOpMode == OP_RSV);
        res    = '0;
        cy     = 1'b0;
        accNew = acc[iInCh];
        case (iOpMode)
            OP_ADD: {cy, res} = sum;
            OP_SUB: {cy, res} = diff;
            OP_AND: res = iInA & iInB;
            OP_OR:  res = iInA | iInB;
            OP_XOR: res = iInA ^ iInB;
            OP_ACC: begin
                {cy, res} = accSum;
                accNew    = accSum[DATA_W-1:0];
            end
            OP_CLR: accNew = '0;
            default: ;
        endcase
    end

    // accumulators update on the strobe edge so a following ACC sees the new value
    always_ff @(posedge iClk or posedge iRsn) begin
        if (iRsn) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
        end else if (iInEnable && !isRsv) begin
            acc[iInCh] <= accNew;
        end
    end

    // stage register holding {ch, carry, C} for the FIFO write one edge later
    always_ff @(posedge iClk or posedge iRsn) begin
        if (iRsn) begin
            stgValid <= 1'b0;
            stgData  <= '0;
        end else begin
            stgValid <= iInEnable && !isRsv;
            stgData  <= {iInCh, cy, res};
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge iClk or posedge iRsn) begin
        if (iRsn) begin
            oErr <= '0;
        end else begin
            if (iInEnable && isRsv) oErr[ERR_RSV] <= 1'b1;
            if (fifoUnf)            oErr[ERR_UNF] <= 1'b1;
            if (fifoOvf)            oErr[ERR_OVF] <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) uFifo (
        .iClk       (iClk),
        .iRsn       (iRsn),
        .iWrEn      (stgValid),
        .iWrData    (stgData),
        .iRdEn      (iOutEnable),
        .oRdData    (rdData),
        .oRdValid   (oOutValid),
        .oEmpty     (oEmpty),
        .oFull      (oFull),
        .oOverflow  (fifoOvf),
        .oUnderflow (fifoUnf)
    );

    assign {oOutCh, oOutCarry, oOutC} = rdData;

endmodule

// File: tb/tb_multi_ch_alu_fifo.sv
// tb_multi_ch_alu_fifo: randomized + directed scoreboard bench for multi_ch_alu_fifo
module tb_multi_ch_alu_fifo;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] c;
        logic        cy;
        logic [1:0]  ch;
    } entry_t;

    logic        iClk, iRsn, iInEnable, iOutEnable;
    logic [1:0]  iInCh;
    logic [2:0]  iOpMode;
    logic [31:0] iInA, iInB;
    logic [31:0] oOutC;
    logic [1:0]  oOutCh;
    logic        oOutCarry, oOutValid, oEmpty, oFull;
    logic [2:0]  oErr;

    multi_ch_alu_fifo #(.DATA_W(32), .NUM_CH(4), .DEPTH(DEPTH)) dut (
        .iClk       (iClk),
        .iRsn       (iRsn),
        .iInEnable  (iInEnable),
        .iInCh      (iInCh),
        .iOpMode    (iOpMode),
        .iInA       (iInA),
        .iInB       (iInB),
        .iOutEnable (iOutEnable),
        .oOutC      (oOutC),
        .oOutCh     (oOutCh),
        .oOutCarry  (oOutCarry),
        .oOutValid  (oOutValid),
        .oEmpty     (oEmpty),
        .oFull      (oFull),
        .oErr       (oErr)
    );

    // reference model state
    entry_t      mq[$];
    entry_t      sb[$];
    entry_t      pend;
    logic        pendValid;
    logic [31:0] macc [4];
    logic [2:0]  merr;
    logic        expValid;

    int passCnt = 0;
    int totalCnt = 0;

    initial begin
        iClk = 0;
        forever #5 iClk = ~iClk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic modelFlush();
        mq.delete();
        sb.delete();
        pendValid = 0;
        merr = '0;
        expValid = 0;
        for (int i = 0; i < 4; i++) macc[i] = '0;
    endtask

    // one clock: drive inputs, then advance the model at the edge
    task automatic cycle(input logic en, input logic [1:0] ch, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic pop);
        logic willPop, wrOk;
        logic [63:0] s;
        iInEnable = en; iInCh = ch; iOpMode = op; iInA = a; iInB = b; iOutEnable = pop;
        @(posedge iClk);
        willPop = pop && (mq.size() > 0);
        wrOk = pendValid && ((mq.size() < DEPTH) || willPop);
        if (pop && !willPop) merr[1] = 1;
        if (pendValid && !wrOk) merr[0] = 1;
        if (willPop) sb.push_back(mq.pop_front());
        if (wrOk) mq.push_back(pend);
        pendValid = 0;
        if (en) begin
            if (op == 3'd7) merr[2] = 1;
            else begin
                pendValid = 1;
                pend.ch = ch;
                pend.cy = 0;
                pend.c = 0;
                case (op)
                    3'd0: begin s = 64'(a) + 64'(b); pend.c = s[31:0]; pend.cy = (s > 64'hFFFF_FFFF); end
                    3'd1: begin pend.c = a - b; pend.cy = (a < b); end
                    3'd2: pend.c = a & b;
                    3'd3: pend.c = a | b;
                    3'd4: pend.c = a ^ b;
                    3'd5: begin
                        s = 64'(macc[ch]) + 64'(a);
                        pend.c = s[31:0];
                        pend.cy = (s > 64'hFFFF_FFFF);
                        macc[ch] = s[31:0];
                    end
                    default: macc[ch] = 0;
                endcase
            end
        end
        expValid = willPop;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        iRsn = 1;
        iInEnable = 0; iOutEnable = 0;
        modelFlush();
        @(posedge iClk);
        #1;
        iRsn = 0;
    endtask

    // monitor: compares status every cycle and scoreboard entries on every delivered pop
    always @(negedge iClk) begin
        entry_t e;
        chk("oOutValid", 32'(oOutValid), 32'(expValid));
        chk("oEmpty", 32'(oEmpty), 32'(mq.size() == 0));
        chk("oFull", 32'(oFull), 32'(mq.size() == DEPTH));
        chk("oErr", 32'(oErr), 32'(merr));
        if (oOutValid) begin
            if (sb.size() == 0) chk("unexpected pop", 32'(oOutValid), 32'd0);
            else begin
                e = sb.pop_front();
                chk("oOutC", oOutC, e.c);
                chk("oOutCarry", 32'(oOutCarry), 32'(e.cy));
                chk("oOutCh", 32'(oOutCh), 32'(e.ch));
            end
        end
    end

    initial begin
        iRsn = 1; iInEnable = 0; iOutEnable = 0; iInCh = 0; iOpMode = 0; iInA = 0; iInB = 0;
        modelFlush();
        @(posedge iClk); #1;
        iRsn = 0;
        chk("reset oOutC", oOutC, 0);
        chk("reset oEmpty", 32'(oEmpty), 1);

        // ADD, SUB, XOR
        cycle(1, 0, 3'd0, 32'h5A5A5A5A, 32'hA5A5A5A5, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(1);
        cycle(1, 1, 3'd1, 32'h0, 32'h1, 0);
        cycle(1, 1, 3'd4, 32'h5A5A5A5A, 32'hFFFFFFFF, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(2);
        chk("hold oOutC", oOutC, 32'hA5A5A5A5);

        // back-to-back ACC on one channel, independent second channel
        cycle(1, 2, 3'd5, 32'h1, 32'hDEAD, 0);
        cycle(1, 2, 3'd5, 32'hFFFFFFFF, 32'h0, 0);
        cycle(1, 3, 3'd5, 32'h7, 32'h0, 0);
        idle(1);
        repeat (3) cycle(0, 0, 0, 0, 0, 1);
        idle(1);

        // overflow, drain, underflow
        for (int i = 0; i < 5; i++) cycle(1, 2'(i), 3'd0, 32'(i * 16), 32'(i), 0);
        idle(2);
        repeat (5) cycle(0, 0, 0, 0, 0, 1);
        idle(1);

        // full FIFO: write and pop on the same edge
        for (int i = 0; i < 4; i++) cycle(1, 1, 3'd3, 32'(i), 32'h100, 0);
        cycle(1, 3, 3'd2, 32'hF0F0, 32'hFF00, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 3'd6, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 1, 3'd7, 1, 1, 0);
        idle(1);

        // reset between strobe and FIFO write
        cycle(1, 2, 3'd5, 32'h55, 0, 0);
        doReset();
        chk("rst oOutC", oOutC, 0);
        chk("rst oErr", 32'(oErr), 0);
        chk("rst oEmpty", 32'(oEmpty), 1);
        cycle(1, 2, 3'd5, 32'h3, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cycle($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
                  a, b, $urandom_range(0, 1) == 1);
            if (i == 200) begin
                doReset();
            end
        end
        idle(1);
        repeat (DEPTH + 2) cycle(0, 0, 0, 0, 0, 1);
        idle(2);
        chk("scoreboard drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/multi_ch_alu_fifo.md
MULTI_CH_ALU_FIFO -- requirements
Module: multi_ch_alu_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter NUM_CH, default 4, channel count (power of 2, >=2); CH_W = log2(NUM_CH).
REQ-003 SHALL have parameter DEPTH, default 4, result FIFO entries (power of 2, >=2).
REQ-004 iClk  input  1  single clock, rising edge.
REQ-005 iRsn  input  1  reset, asynchronous, active-high; port name iRsn retained for port compatibility, polarity fixed active-high.
REQ-006 iInEnable  input  1  one-cycle operand strobe.
REQ-007 iInCh  input  CH_W  channel tag of operands.
REQ-008 iOpMode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ACC, 6 CLR, 7 reserved.
REQ-009 iInA, iInB  input  DATA_W  operands.
REQ-010 iOutEnable  input  1  one-cycle pop strobe.
REQ-011 oOutC  output  DATA_W  popped result.
REQ-012 oOutCh  output  CH_W  channel tag of popped result.
REQ-013 oOutCarry  output  1  carry/borrow of popped result.
REQ-014 oOutValid  output  1  one-cycle pulse, pop delivered data.
REQ-015 oEmpty, oFull  output  1 each  FIFO status.
REQ-016 oErr  output  3  sticky {reserved-op, underflow, overflow}, bits [2:0].

Function
REQ-017 ADD: C = A+B, carry = bit DATA_W of the (DATA_W+1)-bit sum.
REQ-018 SUB: C = A-B mod 2^DATA_W, carry = 1 when A < B (unsigned borrow).
REQ-019 AND/OR/XOR: bitwise on A,B; carry = 0.
REQ-020 ACC: acc[ch] <= acc[ch]+A, C = new acc[ch], carry = sum overflow; iInB ignored.
REQ-021 CLR: acc[ch] <= 0, C = 0, carry = 0.
REQ-022 Reserved op: no FIFO write, oErr[2] set.
REQ-023 Pipeline: strobe sampled at edge N -> result in stage register at N; FIFO write at N+1; oEmpty falls after N+1.
REQ-024 Back-to-back strobes every cycle SHALL be accepted; ACC on same channel consecutively SHALL use the updated accumulator (no hazard).
REQ-025 Pop at edge M with FIFO non-empty: oOutC/oOutCh/oOutCarry updated at M, oOutValid high for cycle after M only.
REQ-026 Pop on empty (after accounting for same-edge write): no data change, oOutValid 0, oErr[1] set.
REQ-027 Write when full and no simultaneous pop: result dropped, FIFO unchanged, oErr[0] set; accumulator update still applies.
REQ-028 Simultaneous write and pop when full: both succeed, count unchanged, no overflow.
REQ-029 Simultaneous write and pop when empty: pop sees empty (underflow), write lands.
REQ-030 Read/write pointers wrap modulo DEPTH; count range 0..DEPTH; oFull = (count==DEPTH), oEmpty = (count==0).
REQ-031 oOutC/oOutCh/oOutCarry SHALL hold last popped value between pops.

Reset
REQ-032 iRsn high SHALL asynchronously clear: pointers, count, stage register, all acc[], oOutC=0, oOutCh=0, oOutCarry=0, oOutValid=0, oEmpty=1, oFull=0, oErr=0.
REQ-033 Reset mid-operation SHALL discard in-flight stage result and all FIFO contents; first strobe after release behaves as from power-up.
REQ-034 FIFO storage array need not be reset.

Structure
REQ-035 Op-code constants (OP_ADD..OP_CLR) and oErr bit indices SHALL live in shared package alu_pkg.
REQ-036 FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH), entry = {ch, carry, C}.
REQ-037 ALU stage and accumulator bank stay in multi_ch_alu_fifo; oErr is cleared only by reset.

Verification
REQ-038 ADD ch0 A=5A5A5A5A B=A5A5A5A5, pop -> oOutC=FFFFFFFF, carry 0, oOutCh 0, oOutValid one cycle.
REQ-039 SUB ch1 A=0 B=1, pop -> oOutC=FFFFFFFF, carry 1; XOR A=5A5A5A5A B=FFFFFFFF -> A5A5A5A5.
REQ-040 ACC ch2 A=1 then A=FFFFFFFF back-to-back, two pops -> 00000001 c0, then 00000000 c1; ACC ch3 A=7 -> 00000007 (channels independent).
REQ-041 DEPTH=4: 5 ADD strobes no pops -> oFull after 4th, oErr[0]=1, pops return first 4 in order, oEmpty after 4th; 5th pop -> oErr[1]=1, oOutValid 0.
REQ-042 Full FIFO, strobe and pop same cycle -> no overflow, oFull stays 1, oldest entry delivered.
REQ-043 Assert iRsn between strobe and FIFO write -> all outputs reset values, oEmpty=1; subsequent ACC ch2 A=3 pops 00000003.
